// File: rtl/gpio_in_pkg.sv
// ============================================================================
// Module  : gpio_in_pkg
// Brief   : Shared GPIO bank codes and warm-up constant.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpio_in_pkg;

    typedef enum logic [1:0] {
        BANK_DATA = 2'd0,
        BANK_FLAG = 2'd1,
        BANK_MASK = 2'd2,
        BANK_RSVD = 2'd3
    } gpio_bank_e;

    // Edge detection is armed only once the warm-up counter reaches this value.
    localparam logic [1:0] c_WARM_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/gpio_in_sync.sv
// ============================================================================
// Module  : gpio_sync
// Brief   : Two-flop synchronizer, cleared to zero on reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_sync #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_s1;
    logic [width-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

`default_nettype wire

// File: rtl/gpio_in.sv
// ============================================================================
// Module  : gpio_in
// Brief   : Synchronized GPIO input port with sticky change flags and IRQ mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int size     = 1,
    parameter int size_idx = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    output logic                  ready_r,
    output logic                  ready_w,
    input  logic [size_idx+1:0]   address,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    input  logic [size*8-1:0]     port_in,
    output logic                  irq
);

    localparam int c_WIDTH = size * 8;

    logic [c_WIDTH-1:0]  w_s2;
    logic [c_WIDTH-1:0]  r_s3;
    logic [c_WIDTH-1:0]  r_flag;
    logic [c_WIDTH-1:0]  r_mask;
    logic [1:0]          r_warm;
    logic [7:0]          r_data_out;
    logic                r_ready_r;
    logic                r_ready_w;
    logic                r_irq;

    gpio_bank_e          w_bank;
    logic [size_idx-1:0] w_idx;
    logic [7:0]          w_rdata;
    logic [c_WIDTH-1:0]  w_clr;
    logic [c_WIDTH-1:0]  w_set;
    logic [c_WIDTH-1:0]  w_mask_nxt;

    gpio_sync #(
        .width (c_WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (port_in),
        .o_q   (w_s2)
    );

    assign w_bank = gpio_bank_e'(address[size_idx+1 -: 2]);
    assign w_idx  = address[size_idx-1:0];

    // Indices at or beyond size match no byte, so they read zero and drop writes.
    always_comb begin
        w_rdata    = 8'h00;
        w_clr      = '0;
        w_mask_nxt = r_mask;
        for (int i = 0; i < size; i++) begin
            if (w_idx == size_idx'(i)) begin
                case (w_bank)
                    BANK_DATA: w_rdata = w_s2[i*8 +: 8];
                    BANK_FLAG: w_rdata = r_flag[i*8 +: 8];
                    BANK_MASK: w_rdata = r_mask[i*8 +: 8];
                    default:   w_rdata = 8'h00;
                endcase
                if (write && (w_bank == BANK_FLAG)) begin
                    w_clr[i*8 +: 8] = data_in;
                end
                if (write && (w_bank == BANK_MASK)) begin
                    w_mask_nxt[i*8 +: 8] = data_in;
                end
            end
        end
    end

    assign w_set = (r_warm == c_WARM_DONE) ? (w_s2 ^ r_s3) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3       <= '0;
            r_flag     <= '0;
            r_mask     <= '0;
            r_warm     <= 2'd0;
            r_data_out <= 8'h00;
            r_ready_r  <= 1'b0;
            r_ready_w  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_s3      <= w_s2;
            // A new edge wins over a same-cycle clear of the same bit.
            r_flag    <= (r_flag & ~w_clr) | w_set;
            r_mask    <= w_mask_nxt;
            r_ready_r <= read;
            r_ready_w <= write;
            r_irq     <= |(r_flag & r_mask);
            if (r_warm != c_WARM_DONE) begin
                r_warm <= r_warm + 2'd1;
            end
            if (read) begin
                r_data_out <= w_rdata;
            end
        end
    end

    assign ready_r  = r_ready_r;
    assign ready_w  = r_ready_w;
    assign data_out = r_data_out;
    assign irq      = r_irq;

endmodule

`default_nettype wire
